fp_normalize_round: RTL

- Parametrised, lane-generic normalise-and-round back end shared by the FP add, multiply and convert pipelines.
- Takes an unnormalised per-lane magnitude, exponent and sign.
- Produces IEEE754 results of configurable format with four rounding modes, full subnormal support, overflow saturation and exception flags.
- Two-stage pipeline with valid/ready backpressure. Sits between the arithmetic datapath and writeback.

---
 rtl/fp_normalize_round.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/fp_normalize_round.sv
// fp_normalize_round: two-stage normalise/round back end shared by
// the FP add, mul and convert pipelines (S1 normalise, S2 round).
module fp_normalize_round #(
  parameter int LANES     = 16,
  parameter int EXP_WIDTH = 8,
  parameter int SIG_WIDTH = 23,
  parameter int IN_WIDTH  = 48,
  parameter int TAG_WIDTH = 8
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [1:0]                             in_round_mode,
  input  logic [TAG_WIDTH-1:0]                   in_tag,
  input  logic [LANES-1:0]                       in_sign,
  input  logic [LANES*(EXP_WIDTH+2)-1:0]         in_exp,
  input  logic [LANES*IN_WIDTH-1:0]              in_mag,
  input  logic [LANES-1:0]                       in_sticky,
  input  logic [LANES-1:0]                       in_is_inf,
  input  logic [LANES-1:0]                       in_is_nan,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [TAG_WIDTH-1:0]                   out_tag,
  output logic [LANES*(1+EXP_WIDTH+SIG_WIDTH)-1:0] out_result,
  output logic [LANES-1:0]                       out_inexact,
  output logic [LANES-1:0]                       out_overflow,
  output logic [LANES-1:0]                       out_underflow
);

  localparam int EW  = EXP_WIDTH;
  localparam int FW  = SIG_WIDTH;
  localparam int IW  = IN_WIDTH;
  localparam int RW  = 1 + EW + FW;
  localparam int LZW = $clog2(IW + 1);
  localparam int XW  = EW + 3;

  localparam logic [1:0] RNE = 2'd0;
  localparam logic [1:0] RTZ = 2'd1;
  localparam logic [1:0] RDN = 2'd2;

  localparam logic [EW+1:0] OVF_E = (EW+2)'((1 << EW) - 1);

  typedef struct packed {
    logic [IW-1:0]   mag;
    logic [EW+1:0]   e;
    logic            sign;
    logic            sticky;
    logic            inf;
    logic            nan;
  } s1_lane_t;

  typedef struct packed {
    logic [RW-1:0] res;
    logic          nx;
    logic          of;
    logic          uf;
  } s2_lane_t;

  function automatic s1_lane_t norm_f(
    input logic          sg,
    input logic [EW+1:0] ex,
    input logic [IW-1:0] m,
    input logic          st,
    input logic          inf,
    input logic          nan
  );
    s1_lane_t                r;
    logic [LZW-1:0]          lz;
    logic [LZW-1:0]          rs;
    logic signed [XW-1:0]    exx;
    logic signed [XW-1:0]    diff;
    logic signed [XW-1:0]    neg;
    logic [IW-1:0]           lost;
    lz = LZW'(IW);
    for (int i = 0; i < IW; i++)
      if (m[i]) lz = LZW'(IW - 1 - i);
    exx  = {ex[EW+1], ex};
    diff = exx - $signed(XW'(lz));
    neg  = -exx;
    r.sign   = sg;
    r.sticky = st;
    r.inf    = inf;
    r.nan    = nan;
    r.e      = '0;
    r.mag    = '0;
    if (m != '0 && diff >= 0) begin
      r.mag = m << lz;
      r.e   = diff[EW+1:0] + (EW+2)'(1);
    end else if (!exx[XW-1]) begin
      r.mag = m << exx[EW+1:0];
    end else begin
      // right shift saturates; everything shifted out folds into sticky
      rs       = (neg > XW'(IW)) ? LZW'(IW) : neg[LZW-1:0];
      lost     = m & ~({IW{1'b1}} << rs);
      r.mag    = m >> rs;
      r.sticky = st | (|lost);
    end
    return r;
  endfunction

  function automatic s2_lane_t round_f(
    input s1_lane_t   a,
    input logic [1:0] md
  );
    s2_lane_t       r;
    logic [FW-1:0]  fr;
    logic [FW:0]    sum;
    logic [EW+1:0]  er;
    logic           g;
    logic           st;
    logic           inc;
    logic           to_inf;
    fr = a.mag[IW-2 -: FW];
    g  = a.mag[IW-2-FW];
    st = a.sticky | (|a.mag[IW-3-FW:0]);
    case (md)
      RNE:     inc = g & (st | fr[0]);
      RTZ:     inc = 1'b0;
      RDN:     inc = a.sign & (g | st);
      default: inc = ~a.sign & (g | st);
    endcase
    // a carry wraps the fraction to zero and bumps e (subnormal -> e=1)
    sum    = {1'b0, fr} + (FW+1)'(inc);
    er     = a.e + (EW+2)'(sum[FW]);
    to_inf = (md == RNE) | ((md == 2'd3) & ~a.sign) | ((md == RDN) & a.sign);
    r = '0;
    if (a.nan) begin
      r.res = {1'b0, {EW{1'b1}}, {FW{1'b1}}};
    end else if (a.inf) begin
      r.res = {a.sign, {EW{1'b1}}, {FW{1'b0}}};
    end else if (er >= OVF_E) begin
      r.res = to_inf ? {a.sign, {EW{1'b1}}, {FW{1'b0}}}
                     : {a.sign, {(EW-1){1'b1}}, 1'b0, {FW{1'b1}}};
      r.nx  = 1'b1;
      r.of  = 1'b1;
    end else begin
      r.res = {a.sign, er[EW-1:0], sum[FW-1:0]};
      r.nx  = g | st;
      r.uf  = (g | st) & (a.e == '0);
    end
    return r;
  endfunction

  logic                 s1_valid;
  logic                 s2_valid;
  logic                 s2_free;
  logic [1:0]           s1_mode;
  logic [TAG_WIDTH-1:0] s1_tag;
  logic [TAG_WIDTH-1:0] s2_tag;
  s1_lane_t             s1_next [LANES];
  s1_lane_t             s1_q    [LANES];
  s2_lane_t             s2_next [LANES];
  s2_lane_t             s2_q    [LANES];

  assign s2_free   = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || s2_free;
  assign out_valid = s2_valid;
  assign out_tag   = s2_tag;

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      s1_next[l] = norm_f(in_sign[l],
                          in_exp[l*(EW+2) +: EW+2],
                          in_mag[l*IW +: IW],
                          in_sticky[l],
                          in_is_inf[l],
                          in_is_nan[l]);
      s2_next[l] = round_f(s1_q[l], s1_mode);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (s2_free)  s2_valid <= s1_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      s1_q    <= s1_next;
      s1_mode <= in_round_mode;
      s1_tag  <= in_tag;
    end
    if (s1_valid && s2_free) begin
      s2_q   <= s2_next;
      s2_tag <= s1_tag;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_out
    assign out_result[l*RW +: RW] = s2_q[l].res;
    assign out_inexact[l]         = s2_q[l].nx;
    assign out_overflow[l]        = s2_q[l].of;
    assign out_underflow[l]       = s2_q[l].uf;
  end

endmodule
